// File: rtl/dcache_pkg.sv
// Shared types and access-size encodings for the data-cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
  localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
  localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
  localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
  localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

  function automatic logic is_word_mode(input logic [2:0] mode);
    return mode == DATA_ADDR_MODE_W;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; one-cycle update.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through D-cache sequencer: hits return in 0 cycles; misses and stores stall
// the CPU from the request cycle through mem_ack, releasing in a one-cycle DONE.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read_en,
  input  logic                  cpu_write_en,
  input  logic [2:0]            cpu_addr_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  cache_fill_en,
  output logic [DATA_WIDTH-1:0] cache_fill_data,
  output logic                  cache_store_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_mode,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [WW-1:0]         wait_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            mode_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  load_q;
  logic                  err_q;

  logic hit_inc, miss_inc, cap_rd, cap_wr, timeout, expired;

  assign expired     = (wait_q == WW'(TIMEOUT - 1));
  assign mem_addr    = addr_q;
  assign mem_wdata   = data_q;
  assign mem_mode    = mode_q;
  assign err_timeout = err_q;

  // Outputs are gated by rst so an in-flight request vanishes the moment reset rises.
  always_comb begin
    state_d         = state_q;
    cpu_stall       = 1'b0;
    cpu_read_data   = '0;
    cache_fill_en   = 1'b0;
    cache_fill_data = '0;
    cache_store_en  = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    cap_rd          = 1'b0;
    cap_wr          = 1'b0;
    timeout         = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_write_en) begin
            cpu_stall = 1'b1;
            cap_wr    = 1'b1;
            state_d   = WRITE;
          end else if (cpu_read_en) begin
            if (cache_hit) begin
              cpu_read_data = cache_rdata;
              hit_inc       = 1'b1;
            end else begin
              cpu_stall = 1'b1;
              cap_rd    = 1'b1;
              miss_inc  = 1'b1;
              state_d   = REFILL;
            end
          end
        end
        REFILL: begin
          mem_req   = 1'b1;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            cache_fill_en   = 1'b1;
            cache_fill_data = mem_rdata;
            state_d         = DONE;
          end else if (expired) begin
            timeout = 1'b1;
            state_d = DONE;
          end
        end
        WRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            // Only full-word stores may allocate; a sub-word miss goes to memory only.
            cache_store_en = cache_hit || is_word_mode(mode_q);
            state_d        = DONE;
          end else if (expired) begin
            timeout = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (load_q) cpu_read_data = resp_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      resp_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_rd) begin
        addr_q <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mode_q <= cpu_addr_mode;
        load_q <= 1'b1;
        wait_q <= '0;
      end else if (cap_wr) begin
        addr_q <= cpu_addr;
        data_q <= cpu_write_data;
        mode_q <= cpu_addr_mode;
        load_q <= 1'b0;
        wait_q <= '0;
      end else if (((state_q == REFILL) || (state_q == WRITE)) && !mem_ack) begin
        wait_q <= wait_q + {{(WW-1){1'b0}}, 1'b1};
      end
      if (cache_fill_en) resp_q <= mem_rdata;
      else if (timeout && (state_q == REFILL)) resp_q <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural cache array and latency-programmable memory around the DUT.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          cpu_read_en, cpu_write_en;
  logic [2:0]    cpu_addr_mode;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_write_data;
  logic          cpu_stall;
  logic [DW-1:0] cpu_read_data;
  logic          cache_hit;
  logic [DW-1:0] cache_rdata;
  logic          cache_fill_en;
  logic [DW-1:0] cache_fill_data;
  logic          cache_store_en;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_mode;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err_timeout;
  logic [CW-1:0] hit_count, miss_count;

  dcache_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_read_en     (cpu_read_en),
    .cpu_write_en    (cpu_write_en),
    .cpu_addr_mode   (cpu_addr_mode),
    .cpu_addr        (cpu_addr),
    .cpu_write_data  (cpu_write_data),
    .cpu_stall       (cpu_stall),
    .cpu_read_data   (cpu_read_data),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .cache_fill_en   (cache_fill_en),
    .cache_fill_data (cache_fill_data),
    .cache_store_en  (cache_store_en),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_mode        (mem_mode),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .err_timeout     (err_timeout),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cache array stand-in: 64 direct-mapped word sets.
  logic [DW-1:0] c_data [64];
  logic [AW-9:0] c_tag  [64];
  logic          c_vld  [64];
  int            fill_cnt  = 0;
  int            store_cnt = 0;

  always_comb begin
    cache_hit   = c_vld[cpu_addr[7:2]] && (c_tag[cpu_addr[7:2]] == cpu_addr[AW-1:8]);
    cache_rdata = c_data[cpu_addr[7:2]];
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] mode, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: r[off*8 +: 8] = wd[7:0];
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: r[off[1]*16 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) c_vld[i] <= 1'b0;
    end else begin
      if (cache_fill_en) begin
        c_data[mem_addr[7:2]] <= cache_fill_data;
        c_tag[mem_addr[7:2]]  <= mem_addr[AW-1:8];
        c_vld[mem_addr[7:2]]  <= 1'b1;
        fill_cnt <= fill_cnt + 1;
      end
      if (cache_store_en) begin
        c_data[mem_addr[7:2]] <= merge(c_data[mem_addr[7:2]], mem_wdata, mem_mode, mem_addr[1:0]);
        if (mem_mode == DATA_ADDR_MODE_W) begin
          c_tag[mem_addr[7:2]] <= mem_addr[AW-1:8];
          c_vld[mem_addr[7:2]] <= 1'b1;
        end
        store_cnt <= store_cnt + 1;
      end
    end
  end

  // Memory: acks in the mem_lat-th cycle of a request; mem_lat == 0 never acks.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] exp_q[$];
  int          mem_lat    = 0;
  logic [31:0] mem_rd_val = '0;
  int          req_cnt    = 0;
  int          wr_seen    = 0;

  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      req_cnt = req_cnt + 1;
      if ((mem_lat != 0) && (req_cnt == mem_lat)) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          wr_t e;
          mem_rdata = '0;
          wr_seen   = wr_seen + 1;
          if (wr_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
            check("wr_mode", mem_mode, e.mode);
          end
        end else begin
          mem_rdata = mem_rd_val;
          check("rd_align", mem_addr[1:0], 0);
        end
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      req_cnt   = 0;
    end
  end

  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input logic [31:0] rval, input logic [31:0] exp_rd, input int exp_stall);
    int n;
    logic [31:0] e;
    @(negedge clk);
    mem_lat        = lat;
    mem_rd_val     = rval;
    cpu_read_en    = rd;
    cpu_write_en   = wr;
    cpu_addr_mode  = mode;
    cpu_addr       = addr;
    cpu_write_data = wdata;
    if (wr) wr_q.push_back({addr, wdata, mode});
    else if (rd) exp_q.push_back(exp_rd);
    #1;
    n = 0;
    while (cpu_stall && (n < 100)) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, n, exp_stall);
    check({tag, "_req_low"}, mem_req, 0);
    if (rd && !wr) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, cpu_read_data, e);
    end else begin
      check({tag, "_rdata_zero"}, cpu_read_data, 0);
    end
    @(posedge clk);
    #1;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, s0, w0;
    rst            = 1'b1;
    cpu_read_en    = 1'b0;
    cpu_write_en   = 1'b0;
    cpu_addr_mode  = DATA_ADDR_MODE_W;
    cpu_addr       = '0;
    cpu_write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", cpu_stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_err", err_timeout, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_rdata", cpu_read_data, 0);

    // Cold miss, then the same address hits.
    f0 = fill_cnt;
    access("miss100", 1, 0, DATA_ADDR_MODE_W, 32'h100, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4);
    check("miss100_fills", fill_cnt - f0, 1);
    access("hit100", 1, 0, DATA_ADDR_MODE_W, 32'h100, 0, 3, 0, 32'hDEADBEEF, 0);
    check("hit100_hits", hit_count, 1);
    check("hit100_misses", miss_count, 1);

    // Word store allocates; later load hits.
    s0 = store_cnt;
    access("stw104", 0, 1, DATA_ADDR_MODE_W, 32'h104, 32'h12345678, 2, 0, 0, 3);
    check("stw104_store_pulses", store_cnt - s0, 1);
    access("hit104", 1, 0, DATA_ADDR_MODE_W, 32'h104, 0, 2, 0, 32'h12345678, 0);
    check("hit104_hits", hit_count, 2);

    // Sub-word store miss is memory-only.
    s0 = store_cnt;
    access("stb20b", 0, 1, DATA_ADDR_MODE_B, 32'h20B, 32'h000000AB, 2, 0, 0, 3);
    check("stb20b_store_pulses", store_cnt - s0, 0);
    access("miss208", 1, 0, DATA_ADDR_MODE_W, 32'h208, 0, 2, 32'hAB000000, 32'hAB000000, 3);
    check("miss208_misses", miss_count, 2);

    // Store wins over a simultaneous load.
    w0 = wr_seen;
    access("both40", 1, 1, DATA_ADDR_MODE_W, 32'h40, 32'h55, 2, 0, 0, 3);
    check("both40_writes", wr_seen - w0, 1);
    check("both40_misses", miss_count, 2);
    check("both40_hits", hit_count, 2);

    // Memory never answers.
    f0 = fill_cnt;
    access("tmo300", 1, 0, DATA_ADDR_MODE_W, 32'h300, 0, 0, 32'h11111111, 32'h0, 1 + TO);
    check("tmo300_err", err_timeout, 1);
    check("tmo300_fills", fill_cnt - f0, 0);
    check("tmo300_misses", miss_count, 3);
    access("hit100b", 1, 0, DATA_ADDR_MODE_W, 32'h100, 0, 2, 0, 32'hDEADBEEF, 0);
    check("err_sticky", err_timeout, 1);
    check("hit100b_hits", hit_count, 3);

    // Reset in the second refill cycle.
    f0 = fill_cnt;
    @(negedge clk);
    mem_lat       = 0;
    cpu_read_en   = 1'b1;
    cpu_addr_mode = DATA_ADDR_MODE_W;
    cpu_addr      = 32'h400;
    #1;
    check("rstmid_req_stall", cpu_stall, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstmid_req_before", mem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_req", mem_req, 0);
    check("rstmid_stall", cpu_stall, 0);
    check("rstmid_hits", hit_count, 0);
    check("rstmid_misses", miss_count, 0);
    check("rstmid_err", err_timeout, 0);
    cpu_read_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_fills", fill_cnt - f0, 0);
    check("rstmid_idle_req", mem_req, 0);
    access("post_rst", 1, 0, DATA_ADDR_MODE_W, 32'h100, 0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 3);
    check("post_rst_misses", miss_count, 1);

    check("wr_q_empty", wr_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
